// File: rtl/cpu_types_pkg.sv
// Shared types for the memory-access stage: word type, stage FSM encoding and
// the low address bit where word-granular comparisons start.
package cpu_types_pkg;
  localparam int WADDR_LSB = 2;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;
endpackage

// File: rtl/ll_sc_link.sv
// LL/SC link register: set by a completed LL, cleared by SC, by a local store
// to the linked word, or by a remote snoop of the linked word.
module ll_sc_link
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              set,
  input  logic              clear,
  input  logic              st_valid,
  input  logic [WORD_W-1:0] req_addr,
  input  logic              snoop_valid,
  input  logic [WORD_W-1:0] snoop_addr,
  input  logic [WORD_W-1:0] chk_addr,
  output logic              sc_ok,
  output logic              link_valid
);
  localparam int HI = WORD_W - 1;

  logic                 link_valid_q, link_valid_d;
  logic [HI:WADDR_LSB]  link_addr_q, link_addr_d;
  logic                 st_match, snoop_match;
  logic                 unused_lsbs;

  // Snoop is checked against the address this cycle's LL would install, so a
  // racing remote write still kills the fresh link.
  always_comb begin
    link_addr_d  = set ? req_addr[HI:WADDR_LSB] : link_addr_q;
    st_match     = st_valid && (req_addr[HI:WADDR_LSB] == link_addr_q);
    snoop_match  = snoop_valid && (snoop_addr[HI:WADDR_LSB] == link_addr_d);
    link_valid_d = (link_valid_q || set) && !clear && !st_match && !snoop_match;
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

  assign sc_ok       = link_valid_q && (chk_addr[HI:WADDR_LSB] == link_addr_q);
  assign link_valid  = link_valid_q;
  assign unused_lsbs = ^{req_addr[WADDR_LSB-1:0], snoop_addr[WADDR_LSB-1:0],
                         chk_addr[WADDR_LSB-1:0]};
endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: holds the EX/M memory request toward the dcache until
// dhit, stalls upstream meanwhile, and hands a registered result to M/WB.
module mem_access_stage
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_dREN,
  input  logic              ex_dWEN,
  input  logic              ex_ll,
  input  logic              ex_sc,
  input  logic [WORD_W-1:0] ex_addr,
  input  logic [WORD_W-1:0] ex_store,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              snoop_valid,
  input  logic [WORD_W-1:0] snoop_addr,
  output logic              dREN,
  output logic              dWEN,
  output logic [WORD_W-1:0] daddr,
  output logic [WORD_W-1:0] dstore,
  output logic              mem_stall,
  output logic              mem_done,
  output logic [WORD_W-1:0] load_data,
  output logic              link_valid
);
  mem_state_t        state_q, state_d;
  logic              req_ren_q, req_ren_d;
  logic              req_wen_q, req_wen_d;
  logic              req_ll_q, req_ll_d;
  logic              req_sc_q, req_sc_d;
  logic [WORD_W-1:0] req_addr_q, req_addr_d;
  logic [WORD_W-1:0] req_store_q, req_store_d;
  logic [WORD_W-1:0] load_data_q, load_data_d;
  logic              mem_op, hit_req, sc_ok;

  assign mem_op  = ex_valid && !flush && (ex_dREN || ex_dWEN);
  assign hit_req = (state_q == REQ) && dhit;

  always_comb begin
    state_d     = state_q;
    req_ren_d   = req_ren_q;
    req_wen_d   = req_wen_q;
    req_ll_d    = req_ll_q;
    req_sc_d    = req_sc_q;
    req_addr_d  = req_addr_q;
    req_store_d = req_store_q;
    load_data_d = load_data_q;
    mem_stall   = 1'b0;
    mem_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          mem_stall = 1'b1;
          if (ex_sc && !sc_ok) begin
            load_data_d = '0;
            state_d     = DONE;
          end else begin
            req_ren_d   = ex_dREN && !ex_dWEN;
            req_wen_d   = ex_dWEN;
            req_ll_d    = ex_ll;
            req_sc_d    = ex_sc;
            req_addr_d  = ex_addr;
            req_store_d = ex_store;
            state_d     = REQ;
          end
        end else begin
          mem_done = ex_valid && !flush;
        end
      end
      REQ: begin
        mem_stall = 1'b1;
        if (dhit) begin
          if (req_ren_q) load_data_d = dmemload;
          else if (req_sc_q) load_data_d = {{(WORD_W-1){1'b0}}, 1'b1};
          state_d = DONE;
        end
      end
      DONE: begin
        mem_done = !flush;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs stay quiet while reset is held, even with a live EX/M latch.
    if (nRST) begin
      mem_stall = 1'b0;
      mem_done  = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state_q     <= IDLE;
      req_ren_q   <= 1'b0;
      req_wen_q   <= 1'b0;
      req_ll_q    <= 1'b0;
      req_sc_q    <= 1'b0;
      req_addr_q  <= '0;
      req_store_q <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      req_ren_q   <= req_ren_d;
      req_wen_q   <= req_wen_d;
      req_ll_q    <= req_ll_d;
      req_sc_q    <= req_sc_d;
      req_addr_q  <= req_addr_d;
      req_store_q <= req_store_d;
      load_data_q <= load_data_d;
    end
  end

  ll_sc_link #(.WORD_W(WORD_W)) u_link (
    .CLK         (CLK),
    .nRST        (nRST),
    .set         (hit_req && req_ll_q),
    .clear       (hit_req && req_sc_q),
    .st_valid    (hit_req && req_wen_q && !req_sc_q),
    .req_addr    (req_addr_q),
    .snoop_valid (snoop_valid),
    .snoop_addr  (snoop_addr),
    .chk_addr    (ex_addr),
    .sc_ok       (sc_ok),
    .link_valid  (link_valid)
  );

  assign dREN      = (state_q == REQ) && req_ren_q;
  assign dWEN      = (state_q == REQ) && req_wen_q;
  assign daddr     = req_addr_q;
  assign dstore    = req_store_q;
  assign load_data = load_data_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, a reset-in-REQ sequence
// and randomized traffic against an operation-level model of the stage.
module tb_mem_access_stage;
  import cpu_types_pkg::*;

  typedef enum int {OP_NOP, OP_LW, OP_SW, OP_LL, OP_SC} op_e;

  typedef struct {
    op_e   op;
    word_t addr;
    word_t store;
    int    lat;
    word_t rdata;
    int    flush_cyc;
    int    snoop_cyc;
    word_t snoop_a;
    word_t exp_load;
    bit    exp_link;
  } vec_t;

  logic  CLK = 1'b0;
  logic  nRST, flush, ex_valid, ex_dREN, ex_dWEN, ex_ll, ex_sc, dhit, snoop_valid;
  word_t ex_addr, ex_store, dmemload, snoop_addr;
  logic  dREN, dWEN, mem_stall, mem_done, link_valid;
  word_t daddr, dstore, load_data;

  int n_pass = 0;
  int n_total = 0;

  // Operation-level model state
  bit          m_lv;
  logic [29:0] m_lw;
  word_t       m_load;

  mem_access_stage #(.WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush), .ex_valid(ex_valid),
    .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN), .ex_ll(ex_ll), .ex_sc(ex_sc),
    .ex_addr(ex_addr), .ex_store(ex_store), .dhit(dhit), .dmemload(dmemload),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .mem_stall(mem_stall), .mem_done(mem_done), .load_data(load_data),
    .link_valid(link_valid)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Drives one instruction through EX/M and checks bus activity, stall and
  // completion timing, load_data and link status. flush_in = -2 means "in DONE".
  task automatic run_op(input string tag, input op_e op, input word_t addr,
                        input word_t store, input int lat, input word_t rdata,
                        input int flush_in, input int snoop_cyc, input word_t snoop_a);
    bit rd, wr, access;
    int d, flush_cyc, exp_done_at;
    int n_ren, n_wen, n_bad, n_stall, n_done, done_at;
    n_ren = 0; n_wen = 0; n_bad = 0; n_stall = 0; n_done = 0; done_at = -1;
    rd = (op == OP_LW) || (op == OP_LL);
    wr = (op == OP_SW) || (op == OP_SC);
    access = rd || (op == OP_SW) || (op == OP_SC && m_lv && m_lw == addr[31:2]);
    d = access ? lat + 1 : ((op == OP_SC) ? 1 : 0);
    flush_cyc = (flush_in == -2) ? d : flush_in;
    exp_done_at = (flush_cyc == d) ? -1 : d;
    for (int c = 0; c <= d + 1; c++) begin
      @(posedge CLK); #1;
      ex_valid = (c <= d);
      ex_dREN  = rd;
      ex_dWEN  = wr;
      ex_ll    = (op == OP_LL);
      ex_sc    = (op == OP_SC);
      if (access && c >= 1 && c <= lat) begin
        ex_addr  = $urandom;
        ex_store = $urandom;
      end else begin
        ex_addr  = addr;
        ex_store = store;
      end
      flush       = (c == flush_cyc);
      snoop_valid = (c == snoop_cyc);
      snoop_addr  = (c == snoop_cyc) ? snoop_a : $urandom;
      dhit        = !(access && c >= 1 && c < lat);
      dmemload    = (access && c == lat) ? rdata : $urandom;
      @(negedge CLK);
      if (dREN) n_ren++;
      if (dWEN) n_wen++;
      if (dREN && dWEN) n_bad++;
      if ((dREN || dWEN) && daddr !== addr) n_bad++;
      if (dWEN && dstore !== store) n_bad++;
      if (mem_stall) n_stall++;
      if (mem_done) begin n_done++; done_at = c; end
      if (access && c == lat) begin
        case (op)
          OP_LW: m_load = rdata;
          OP_LL: begin m_load = rdata; m_lv = 1'b1; m_lw = addr[31:2]; end
          OP_SC: begin m_load = 32'd1; m_lv = 1'b0; end
          OP_SW: if (m_lw == addr[31:2]) m_lv = 1'b0;
          default: ;
        endcase
      end
      if (!access && op == OP_SC && c == 0) m_load = 32'd0;
      if (c == snoop_cyc && m_lw == snoop_a[31:2]) m_lv = 1'b0;
    end
    chk({tag, " dREN_cycles"}, n_ren, (access && rd) ? lat : 0);
    chk({tag, " dWEN_cycles"}, n_wen, (access && wr) ? lat : 0);
    chk({tag, " req_bus_errors"}, n_bad, 0);
    chk({tag, " stall_cycles"}, n_stall, access ? lat + 1 : ((op == OP_SC) ? 1 : 0));
    chk({tag, " done_pulses"}, n_done, (exp_done_at < 0) ? 0 : 1);
    chk({tag, " done_cycle"}, done_at, exp_done_at);
    chk({tag, " load_data"}, load_data, m_load);
    chk({tag, " link_valid"}, link_valid, m_lv);
  endtask

  vec_t  tbl[18];
  word_t bases[3];
  op_e   r_op;
  word_t r_addr, r_snoop;
  int    r_lat, r_flush, r_snc;

  initial begin
    nRST = 1'b1; flush = 1'b0; ex_valid = 1'b1; ex_dREN = 1'b1; ex_dWEN = 1'b0;
    ex_ll = 1'b0; ex_sc = 1'b0; ex_addr = 32'h100; ex_store = 32'h55;
    dhit = 1'b1; dmemload = 32'hFFFF_FFFF; snoop_valid = 1'b0; snoop_addr = 32'h0;
    m_lv = 1'b0; m_lw = '0; m_load = 32'h0;
    bases[0] = 32'h200; bases[1] = 32'h204; bases[2] = 32'h300;

    tbl[0]  = '{OP_LW,  32'h100, 32'h0,  2, 32'hDEADBEEF, -1, -1, 32'h0,   32'hDEADBEEF, 1'b0};
    tbl[1]  = '{OP_LL,  32'h200, 32'h0,  1, 32'h11,       -1, -1, 32'h0,   32'h11,       1'b1};
    tbl[2]  = '{OP_SC,  32'h200, 32'h5,  1, 32'h0,        -1, -1, 32'h0,   32'h1,        1'b0};
    tbl[3]  = '{OP_LL,  32'h200, 32'h0,  1, 32'h22,       -1, -1, 32'h0,   32'h22,       1'b1};
    tbl[4]  = '{OP_NOP, 32'h0,   32'h0,  1, 32'h0,        -1,  0, 32'h200, 32'h22,       1'b0};
    tbl[5]  = '{OP_SC,  32'h200, 32'h6,  1, 32'h0,        -1, -1, 32'h0,   32'h0,        1'b0};
    tbl[6]  = '{OP_LL,  32'h200, 32'h0,  1, 32'h33,       -1, -1, 32'h0,   32'h33,       1'b1};
    tbl[7]  = '{OP_SW,  32'h204, 32'h77, 1, 32'h0,        -1, -1, 32'h0,   32'h33,       1'b1};
    tbl[8]  = '{OP_SC,  32'h200, 32'h9,  1, 32'h0,        -1, -1, 32'h0,   32'h1,        1'b0};
    tbl[9]  = '{OP_LL,  32'h200, 32'h0,  1, 32'h44,       -1, -1, 32'h0,   32'h44,       1'b1};
    tbl[10] = '{OP_SW,  32'h200, 32'h88, 1, 32'h0,        -1, -1, 32'h0,   32'h44,       1'b0};
    tbl[11] = '{OP_SC,  32'h200, 32'hA,  1, 32'h0,        -1, -1, 32'h0,   32'h0,        1'b0};
    tbl[12] = '{OP_SW,  32'h300, 32'hBB, 3, 32'h0,         1, -1, 32'h0,   32'h0,        1'b0};
    tbl[13] = '{OP_SW,  32'h300, 32'hCC, 1, 32'h0,         2, -1, 32'h0,   32'h0,        1'b0};
    tbl[14] = '{OP_LL,  32'h208, 32'h0,  2, 32'h55,       -1,  2, 32'h208, 32'h55,       1'b0};
    tbl[15] = '{OP_LL,  32'h20C, 32'h0,  1, 32'h66,       -1,  1, 32'h200, 32'h66,       1'b1};
    tbl[16] = '{OP_LL,  32'h20C, 32'h0,  1, 32'h77,       -1,  1, 32'h20F, 32'h77,       1'b0};
    tbl[17] = '{OP_NOP, 32'h0,   32'h0,  1, 32'h0,         0, -1, 32'h0,   32'h77,       1'b0};

    // Reset state with a live memory instruction presented
    repeat (2) @(negedge CLK);
    chk("rst dREN", dREN, 0);
    chk("rst dWEN", dWEN, 0);
    chk("rst mem_stall", mem_stall, 0);
    chk("rst mem_done", mem_done, 0);
    chk("rst load_data", load_data, 0);
    chk("rst link_valid", link_valid, 0);
    chk("rst daddr", daddr, 0);
    chk("rst dstore", dstore, 0);
    @(posedge CLK); #1;
    nRST = 1'b0; ex_valid = 1'b0; dhit = 1'b0;
    @(negedge CLK);
    chk("idle mem_stall", mem_stall, 0);
    chk("idle dREN", dREN, 0);

    for (int i = 0; i < 18; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].store, tbl[i].lat,
             tbl[i].rdata, tbl[i].flush_cyc, tbl[i].snoop_cyc, tbl[i].snoop_a);
      chk($sformatf("vec%0d table_load", i), load_data, tbl[i].exp_load);
      chk($sformatf("vec%0d table_link", i), link_valid, tbl[i].exp_link);
    end

    // Reset asserted between clock edges while a load is outstanding
    run_op("pre_rst", OP_LL, 32'h200, 32'h0, 1, 32'h99, -1, -1, 32'h0);
    @(posedge CLK); #1;
    ex_valid = 1'b1; ex_dREN = 1'b1; ex_dWEN = 1'b0; ex_ll = 1'b0; ex_sc = 1'b0;
    ex_addr = 32'h100; dhit = 1'b0; flush = 1'b0; snoop_valid = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("midreq dREN", dREN, 1);
    chk("midreq mem_stall", mem_stall, 1);
    #2 nRST = 1'b1;
    #1;
    chk("async_rst dREN", dREN, 0);
    chk("async_rst dWEN", dWEN, 0);
    chk("async_rst mem_stall", mem_stall, 0);
    chk("async_rst mem_done", mem_done, 0);
    chk("async_rst link_valid", link_valid, 0);
    chk("async_rst load_data", load_data, 0);
    @(posedge CLK); #1;
    nRST = 1'b0; ex_valid = 1'b0;
    m_lv = 1'b0; m_load = 32'h0;
    run_op("post_rst", OP_LW, 32'h100, 32'h0, 1, 32'h12345678, -1, -1, 32'h0);

    for (int i = 0; i < 40; i++) begin
      r_op   = op_e'($urandom_range(0, 4));
      r_addr = bases[$urandom_range(0, 2)] + $urandom_range(0, 3);
      r_lat  = $urandom_range(1, 3);
      if (r_op == OP_NOP) r_flush = ($urandom_range(0, 1) == 1) ? 0 : -1;
      else begin
        case ($urandom_range(0, 3))
          1: r_flush = 1;
          2: r_flush = -2;
          default: r_flush = -1;
        endcase
      end
      case ($urandom_range(0, 2))
        0: r_snc = 0;
        1: r_snc = r_lat;
        default: r_snc = -1;
      endcase
      r_snoop = bases[$urandom_range(0, 2)] + $urandom_range(0, 3);
      run_op($sformatf("rnd%0d", i), r_op, r_addr, $urandom, r_lat, $urandom,
             r_flush, r_snc, r_snoop);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
